// File: rtl/seg_chain_if.sv
// Bundle between the display-frame formatter (master) and the 595 chain
// driver (slave). The driver's pin-side outputs travel in the same bundle so
// a single port carries the whole block boundary.
//
// Handshake: start is a request qualifier and busy is the inverse of ready.
// A transfer is accepted on a rising clk edge where start=1 and busy=0, and
// data is sampled on that edge only. start while busy=1 is dropped, not
// queued. done pulses for one clk once the latch pulse has finished.
interface seg_chain_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              done;
  logic              seg_srclk;
  logic              seg_ser;
  logic              seg_rclk;
  logic [1:0]        dbg_state;

  modport master (
    output start, data,
    input  busy, done, seg_srclk, seg_ser, seg_rclk, dbg_state
  );

  modport slave (
    input  start, data,
    output busy, done, seg_srclk, seg_ser, seg_rclk, dbg_state
  );
endinterface

// File: rtl/seg_chain_drv.sv
// Serialises an N-digit 7-segment frame into a daisy-chained 595 shift
// register chain. SRCLK is generated from clk with a programmable divider;
// a single RCLK pulse latches the frame once all bits are shifted.
// Digit N-1 leaves first so it ends up farthest down the chain.
module seg_chain_drv #(
  parameter int NUM_DIGITS     = 4,
  parameter int BITS_PER_DIGIT = 8,
  parameter int CLK_DIV        = 2,
  parameter int MSB_FIRST      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  seg_chain_if.slave  bus
);
  localparam int FRAME_W = NUM_DIGITS * BITS_PER_DIGIT;
  localparam int CNT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SH_LO = 2'd1,
    SH_HI = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               srclk_q, srclk_d;
  logic               ser_q, ser_d;
  logic               rclk_q, rclk_d;
  logic [FRAME_W-1:0] data_ord;

  // Rearrange the frame so serial order is always from the top bit down:
  // LSB-first digits are bit-reversed in place, digit order is untouched.
  function automatic logic [FRAME_W-1:0] order_frame(input logic [FRAME_W-1:0] d);
    logic [FRAME_W-1:0] o;
    o = d;
    if (MSB_FIRST == 0) begin
      for (int dg = 0; dg < NUM_DIGITS; dg++) begin
        for (int b = 0; b < BITS_PER_DIGIT; b++) begin
          o[dg*BITS_PER_DIGIT + b] = d[dg*BITS_PER_DIGIT + BITS_PER_DIGIT - 1 - b];
        end
      end
    end
    return o;
  endfunction

  assign data_ord = order_frame(bus.data);

  // State and all output registers; reset leaves the chain's latched frame untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      srclk_q <= 1'b0;
      ser_q   <= 1'b0;
      rclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      srclk_q <= srclk_d;
      ser_q   <= ser_d;
      rclk_q  <= rclk_d;
    end
  end

  // Next-state and next-output logic; frame_q holds the bits still to send
  // (the bit on ser has already been shifted out of it).
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    srclk_d = srclk_q;
    ser_d   = ser_q;
    rclk_d  = rclk_q;
    case (state_q)
      IDLE: begin
        srclk_d = 1'b0;
        rclk_d  = 1'b0;
        ser_d   = 1'b0;
        busy_d  = 1'b0;
        if (bus.start) begin
          state_d = SH_LO;
          frame_d = {data_ord[FRAME_W-2:0], 1'b0};
          ser_d   = data_ord[FRAME_W-1];
          cnt_d   = CNT_LAST;
          div_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SH_LO: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          srclk_d = 1'b1;
          state_d = SH_HI;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SH_HI: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          srclk_d = 1'b0;
          if (cnt_q == '0) begin
            rclk_d  = 1'b1;
            state_d = LATCH;
          end else begin
            cnt_d   = cnt_q - CNT_W'(1);
            ser_d   = frame_q[FRAME_W-1];
            frame_d = {frame_q[FRAME_W-2:0], 1'b0};
            state_d = SH_LO;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      LATCH: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          rclk_d  = 1'b0;
          ser_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        srclk_d = 1'b0;
        rclk_d  = 1'b0;
        ser_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.seg_srclk = srclk_q;
  assign bus.seg_ser   = ser_q;
  assign bus.seg_rclk  = rclk_q;
  assign bus.dbg_state = state_q;
endmodule
